dma_job_sched: RTL and testbench

Sequences one systolic-array job across the four DMA channels of the accelerator top: ch0 = K (weights, MM2S), ch1 = X (MM2S), ch2 = A (accumulator-in, MM2S), ch3 = Y (output, S2MM).
- On start, latches per-channel base address and byte count from the config registers.
- Splits each transfer into DMA commands of at most MAX_CMD_BYTES.
- Tracks completions and reports job done to the AXI-lite register block.

---
 rtl/dma_job_sched_if.sv | 26 ++
 rtl/dma_job_sched.sv | 137 +++++++++++++
 tb/tb_dma_job_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_job_sched_if.sv
// Command/completion bus between the job scheduler (master) and the DMA engine (slave).
// Handshake: a command transfers on a rising edge where cmd_valid[i] && cmd_ready[i]; while
// cmd_valid[i]=1 and cmd_ready[i]=0 the fields hold and cmd_valid[i] stays high.
// cmp_valid[i] is a one-cycle pulse per finished command with no back-pressure.
interface dma_job_sched_if #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
);
  logic [N_CH-1:0]        cmd_valid;
  logic [N_CH-1:0]        cmd_ready;
  logic [N_CH*ADDR_W-1:0] cmd_addr;
  logic [N_CH*LEN_W-1:0]  cmd_bytes;
  logic [N_CH-1:0]        cmd_last;
  logic [N_CH-1:0]        cmp_valid;

  modport master (
    output cmd_valid, cmd_addr, cmd_bytes, cmd_last,
    input  cmd_ready, cmp_valid
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_bytes, cmd_last,
    output cmd_ready, cmp_valid
  );
endinterface

// File: rtl/dma_job_sched.sv
// Sequences one systolic-array job over the K/X/A/Y DMA channels, chunking each transfer.
// Defining SCHED_PERF_EN adds the perf_cycles busy-cycle counter output.
module dma_job_sched #(
  parameter int N_CH          = 4,
  parameter int ADDR_W        = 32,
  parameter int LEN_W         = 32,
  parameter int MAX_CMD_BYTES = 4096,
  parameter int MAX_OUT       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_CH*ADDR_W-1:0] cfg_addr,
  input  logic [N_CH*LEN_W-1:0]  cfg_bytes,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             state_dbg,
`ifdef SCHED_PERF_EN
  output logic [31:0]            perf_cycles,
`endif
  dma_job_sched_if.master        dma
);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [LEN_W-1:0] MAX_B = LEN_W'(MAX_CMD_BYTES);
  localparam logic [OUT_W-1:0] MAX_O = OUT_W'(MAX_OUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] next_addr [N_CH];
  logic [LEN_W-1:0]  rem_bytes [N_CH];
  logic [OUT_W-1:0]  outst     [N_CH];
  logic [OUT_W-1:0]  outst_nxt [N_CH];
  logic [N_CH-1:0]   hs;
  logic [N_CH-1:0]   cmp_ok;
  logic              all_rem_zero;
  logic              all_out_zero;

  function automatic logic [LEN_W-1:0] clip(input logic [LEN_W-1:0] b);
    return (b > MAX_B) ? MAX_B : b;
  endfunction

  assign state_dbg = state;

  // A completion only counts against a channel that has something in flight.
  always_comb begin
    hs           = dma.cmd_valid & dma.cmd_ready;
    cmp_ok       = '0;
    outst_nxt    = '{default: '0};
    all_rem_zero = 1'b1;
    all_out_zero = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      cmp_ok[i]    = dma.cmp_valid[i] && (outst[i] != '0);
      outst_nxt[i] = outst[i] + OUT_W'(hs[i]) - OUT_W'(cmp_ok[i]);
      if (rem_bytes[i] != '0) all_rem_zero = 1'b0;
      if (outst[i] != '0)     all_out_zero = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      dma.cmd_valid <= '0;
      dma.cmd_addr  <= '0;
      dma.cmd_bytes <= '0;
      dma.cmd_last  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        next_addr[i] <= '0;
        rem_bytes[i] <= '0;
        outst[i]     <= '0;
      end
`ifdef SCHED_PERF_EN
      perf_cycles <= '0;
`endif
    end else begin
      done <= 1'b0;
      if ((dma.cmp_valid & ~cmp_ok) != '0) err <= 1'b1;
      for (int i = 0; i < N_CH; i++) outst[i] <= outst_nxt[i];
`ifdef SCHED_PERF_EN
      if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ISSUE;
            busy  <= 1'b1;
`ifdef SCHED_PERF_EN
            perf_cycles <= '0;
`endif
            // First command of each channel is presented straight from the config.
            for (int i = 0; i < N_CH; i++) begin
              next_addr[i]                         <= cfg_addr[i*ADDR_W +: ADDR_W];
              rem_bytes[i]                         <= cfg_bytes[i*LEN_W +: LEN_W];
              outst[i]                             <= '0;
              dma.cmd_valid[i]                     <= (cfg_bytes[i*LEN_W +: LEN_W] != '0);
              dma.cmd_addr[i*ADDR_W +: ADDR_W]     <= cfg_addr[i*ADDR_W +: ADDR_W];
              dma.cmd_bytes[i*LEN_W +: LEN_W]      <= clip(cfg_bytes[i*LEN_W +: LEN_W]);
              dma.cmd_last[i]                      <= (cfg_bytes[i*LEN_W +: LEN_W] <= MAX_B);
            end
          end
        end
        S_ISSUE: begin
          for (int i = 0; i < N_CH; i++) begin
            if (hs[i]) begin
              next_addr[i]     <= next_addr[i] + ADDR_W'(dma.cmd_bytes[i*LEN_W +: LEN_W]);
              rem_bytes[i]     <= rem_bytes[i] - dma.cmd_bytes[i*LEN_W +: LEN_W];
              dma.cmd_valid[i] <= 1'b0;
            end else if (!dma.cmd_valid[i] && (rem_bytes[i] != '0) && (outst_nxt[i] < MAX_O)) begin
              dma.cmd_valid[i]                 <= 1'b1;
              dma.cmd_addr[i*ADDR_W +: ADDR_W] <= next_addr[i];
              dma.cmd_bytes[i*LEN_W +: LEN_W]  <= clip(rem_bytes[i]);
              dma.cmd_last[i]                  <= (rem_bytes[i] <= MAX_B);
            end
          end
          if (all_rem_zero) state <= S_WAIT;
        end
        S_WAIT: begin
          if (all_out_zero) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_job_sched.sv
// Randomized scoreboard bench for dma_job_sched: reference model expands each job into
// its command list; a monitor pops and compares on every command handshake and done pulse.
`timescale 1ns/1ps
module tb_dma_job_sched;
  localparam int N_CH    = 4;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 32;
  localparam int MAXB    = 4096;
  localparam int EW      = 2 + ADDR_W + LEN_W + 1;

  // ---------------- clock / reset / DUT ----------------
  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [N_CH*ADDR_W-1:0] cfg_addr = '0;
  logic [N_CH*LEN_W-1:0]  cfg_bytes = '0;
  logic                   busy, done, err;
  logic [1:0]             state_dbg;
`ifdef SCHED_PERF_EN
  logic [31:0]            perf_cycles;
`endif

  dma_job_sched_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dif ();

  dma_job_sched #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_CMD_BYTES(MAXB), .MAX_OUT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_addr  (cfg_addr),
    .cfg_bytes (cfg_bytes),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg),
`ifdef SCHED_PERF_EN
    .perf_cycles (perf_cycles),
`endif
    .dma       (dif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  acc_n [N_CH];
  int  cmp_n [N_CH];
  int  drop_n [N_CH];
  int  req_n [N_CH];
  int  srv_n [N_CH];
  int  spur_req [N_CH];
  int  spur_srv [N_CH];
  int  done_cnt = 0;
  int  start_cyc = 0;
  int  last_cmp_cyc = 0;
  bit  job_has_cmds = 1'b0;
  bit  err_exp = 1'b0;
  bit  cmp_en = 1'b0;
  int  rdy_pct = 100;
  int  cmp_pct = 100;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transfer is a run of max-size chunks with a short tail.
  task automatic model_push(input int c, input logic [31:0] addr, input logic [31:0] bytes);
    logic [31:0] a;
    logic [31:0] rem;
    logic [31:0] b;
    a   = addr;
    rem = bytes;
    while (rem != 0) begin
      b = (rem > 32'(MAXB)) ? 32'(MAXB) : rem;
      exp_q.push_back({2'(c), a, b, (rem <= 32'(MAXB))});
      a   = a + b;
      rem = rem - b;
    end
  endtask

  function automatic int pend(input int c);
    return acc_n[c] - cmp_n[c] - drop_n[c];
  endfunction

  // ---------------- driver processes ----------------
  initial begin
    dif.cmd_ready = '0;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < N_CH; c++) dif.cmd_ready[c] = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  initial begin
    dif.cmp_valid = '0;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < N_CH; c++) begin
        dif.cmp_valid[c] = 1'b0;
        if (spur_req[c] != spur_srv[c]) begin
          dif.cmp_valid[c] = 1'b1;
          spur_srv[c]++;
        end else if (pend(c) > 0 &&
                     (req_n[c] != srv_n[c] || (cmp_en && $urandom_range(0, 99) < cmp_pct))) begin
          dif.cmp_valid[c] = 1'b1;
          if (req_n[c] != srv_n[c]) srv_n[c]++;
          cmp_n[c]++;
          last_cmp_cyc = cyc;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit                     hold [N_CH];
  logic [ADDR_W+LEN_W:0]  held [N_CH];
  logic [ADDR_W+LEN_W:0]  mon_f;
  int                     mon_idx;
  int                     exp_cyc;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int c = 0; c < N_CH; c++) hold[c] = 1'b0;
      end else begin
        for (int c = 0; c < N_CH; c++) begin
          mon_f = {dif.cmd_addr[c*ADDR_W +: ADDR_W], dif.cmd_bytes[c*LEN_W +: LEN_W], dif.cmd_last[c]};
          if (hold[c]) begin
            check("valid_held_until_ready", {{(EW-1){1'b0}}, dif.cmd_valid[c]}, 1);
            if (dif.cmd_valid[c]) check("fields_stable_while_stalled", {2'b0, mon_f}, {2'b0, held[c]});
          end
          if (dif.cmd_valid[c] && dif.cmd_ready[c]) begin
            acc_n[c]++;
            hold[c] = 1'b0;
            mon_idx = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
              if (exp_q[k][EW-1 -: 2] == 2'(c)) begin
                mon_idx = k;
                break;
              end
            end
            if (mon_idx < 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL cmd_unexpected: ch%0d got 0x%0h, expected no command (cycle %0d)", c, mon_f, cyc);
            end else begin
              check("cmd_fields", {2'(c), mon_f}, exp_q[mon_idx]);
              exp_q.delete(mon_idx);
            end
          end else if (dif.cmd_valid[c]) begin
            hold[c] = 1'b1;
            held[c] = mon_f;
          end else begin
            hold[c] = 1'b0;
          end
        end
        if (done) begin
          done_cnt++;
          exp_cyc = job_has_cmds ? last_cmp_cyc + 2 : start_cyc + 3;
          check("done_cycle", cyc, exp_cyc);
          check("busy_low_at_done", {{(EW-1){1'b0}}, busy}, 0);
          check("all_cmds_seen_at_done", exp_q.size(), 0);
          check("err_at_done", {{(EW-1){1'b0}}, err}, {{(EW-1){1'b0}}, err_exp});
`ifdef SCHED_PERF_EN
          check("perf_cycles_at_done", perf_cycles, exp_cyc - start_cyc - 1);
`endif
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      {{(EW-1){1'b0}}, busy}, 0);
    check({tag, "_done"},      {{(EW-1){1'b0}}, done}, 0);
    check({tag, "_err"},       {{(EW-1){1'b0}}, err}, 0);
    check({tag, "_cmd_valid"}, dif.cmd_valid, 0);
    check({tag, "_cmd_addr"},  dif.cmd_addr, 0);
    check({tag, "_cmd_bytes"}, dif.cmd_bytes, 0);
    check({tag, "_cmd_last"},  dif.cmd_last, 0);
    check({tag, "_state"},     state_dbg, 0);
`ifdef SCHED_PERF_EN
    check({tag, "_perf"},      perf_cycles, 0);
`endif
  endtask

  task automatic do_reset();
    cmp_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < N_CH; c++) drop_n[c] = acc_n[c] - cmp_n[c];
    exp_q.delete();
    err_exp = 1'b0;
  endtask

  task automatic run_job(input logic [N_CH*ADDR_W-1:0] addrs, input logic [N_CH*LEN_W-1:0] bytes);
    logic [N_CH-1:0] mask;
    mask = '0;
    for (int c = 0; c < N_CH; c++) begin
      model_push(c, addrs[c*ADDR_W +: ADDR_W], bytes[c*LEN_W +: LEN_W]);
      mask[c] = (bytes[c*LEN_W +: LEN_W] != 0);
    end
    job_has_cmds = (mask != '0);
    @(posedge clk); #1;
    cfg_addr  = addrs;
    cfg_bytes = bytes;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
    cfg_addr  = {$urandom, $urandom, $urandom, $urandom};
    cfg_bytes = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check("busy_after_start", {{(EW-1){1'b0}}, busy}, 1);
    check("first_cmd_valid_mask", dif.cmd_valid, mask);
  endtask

  task automatic wait_done(input int limit);
    int  d0;
    bit  got;
    d0  = done_cnt;
    got = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    check("done_within_budget", {{(EW-1){1'b0}}, got}, 1);
    repeat (3) @(negedge clk);
    check("single_done_pulse", done_cnt - d0, 1);
    if (!got) do_reset();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [N_CH*ADDR_W-1:0] a;
    logic [N_CH*LEN_W-1:0]  b;
    bit                     ok;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // All channels unused: busy for two cycles, done on the third.
    rdy_pct = 100; cmp_pct = 100; cmp_en = 1'b1;
    run_job('0, '0);
    @(negedge clk);
    check("zero_job_busy_t2", {{(EW-1){1'b0}}, busy}, 1);
    check("zero_job_no_valid", dif.cmd_valid, 0);
    wait_done(20);

    // Single channel chunking with immediate completions.
    a = '0; b = '0;
    a[0 +: 32] = 32'h1000; b[0 +: 32] = 32'd10000;
    ok = 1'b0;
    run_job(a, b);
    wait_done(100);
    check("ch0_cmd_count", acc_n[0], 3);

    // All channels 8192, random ready, completions withheld until everything is issued.
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {32'd8192, 32'd8192, 32'd8192, 32'd8192};
    rdy_pct = 50; cmp_en = 1'b0;
    for (int c = 0; c < N_CH; c++) drop_n[c] = acc_n[c] - cmp_n[c] - pend(c) + drop_n[c];
    run_job(a, b);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (pend(0) == 2 && pend(1) == 2 && pend(2) == 2 && pend(3) == 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("all_issued_two_each", {{(EW-1){1'b0}}, ok}, 1);
    repeat (8) begin
      @(negedge clk);
      check("no_valid_beyond_rem", dif.cmd_valid, 0);
    end
    cmp_en = 1'b1;
    wait_done(200);

    // Outstanding limit on ch3: five commands, no completions until four are out.
    a = '0; b = '0;
    a[3*32 +: 32] = 32'h8000_0000; b[3*32 +: 32] = 32'd20480;
    rdy_pct = 100; cmp_en = 1'b0;
    run_job(a, b);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (pend(3) == 4) begin
        ok = 1'b1;
        break;
      end
    end
    check("maxout_four_issued", {{(EW-1){1'b0}}, ok}, 1);
    repeat (6) begin
      @(negedge clk);
      check("maxout_valid_held_low", {{(EW-1){1'b0}}, dif.cmd_valid[3]}, 0);
    end
    req_n[3]++;
    @(negedge clk);
    check("maxout_valid_low_during_cmp", {{(EW-1){1'b0}}, dif.cmd_valid[3]}, 0);
    @(negedge clk);
    check("maxout_fifth_cmd_next_cycle", {{(EW-1){1'b0}}, dif.cmd_valid[3]}, 1);
    cmp_en = 1'b1;
    wait_done(100);

    // Spurious completion in IDLE sets sticky err; a start while busy is ignored.
    spur_req[2]++;
    repeat (3) @(negedge clk);
    check("err_after_spurious_cmp", {{(EW-1){1'b0}}, err}, 1);
    err_exp = 1'b1;
    a = '0; b = '0;
    a[2*32 +: 32] = 32'h0004_0000; b[2*32 +: 32] = 32'd20000;
    rdy_pct = 50; cmp_pct = 50;
    run_job(a, b);
    repeat (2) @(posedge clk);
    #1;
    cfg_bytes = {32'd100, 32'd100, 32'd100, 32'd100};
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    wait_done(400);
    check("err_sticky_through_job", {{(EW-1){1'b0}}, err}, 1);

    // Reset while waiting on three outstanding commands, then a clean job.
    a = '0; b = '0;
    a[1*32 +: 32] = 32'h0010_0000; b[1*32 +: 32] = 32'd12288;
    rdy_pct = 100; cmp_en = 1'b0;
    run_job(a, b);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (pend(1) == 3) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    check("abort_three_outstanding", {{(EW-1){1'b0}}, ok}, 1);
    check("abort_in_wait_state", state_dbg, 2);
    do_reset();
    @(negedge clk);
    check_reset_outputs("abort");
    cmp_en = 1'b1; cmp_pct = 70; rdy_pct = 70;
    a[0 +: 32] = 32'h0000_2000; b[0 +: 32] = 32'd5000;
    run_job(a, b);
    wait_done(300);

    // Randomized jobs, including address wrap at the top of the space.
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < N_CH; c++) begin
        b[c*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 18000));
        a[c*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_E000 + 32'($urandom_range(0, 4095))
                                                     : $urandom;
      end
      rdy_pct = $urandom_range(20, 100);
      cmp_pct = $urandom_range(20, 100);
      cmp_en  = 1'b1;
      run_job(a, b);
      wait_done(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
